// File: rtl/ram_row_reader.sv
// ============================================================================
// Module   : ram_row_reader
// Brief    : Read-side master for the 32-row matrix RAM. Fetches a run of
//            consecutive rows and serialises each row into 32 elements on a
//            valid/ready stream for the rotation / pivot-search units.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_row_reader #(
    parameter int RD_LAT = 1,   // RAM read latency, 1..4 cycles
    parameter int ADDR_W = 5,   // row address width
    parameter int WORD_W = 32   // element width
) (
    input  logic                   clk,
    input  logic                   reset,          // asynchronous, active-low
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_row,
    input  logic [ADDR_W:0]        num_rows,
    output logic                   busy,
    output logic                   done,
    output logic                   ram_ena,
    output logic                   ram_read_write,
    output logic [ADDR_W-1:0]      ram_address,
    input  logic [32*WORD_W-1:0]   ram_data_out,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [WORD_W-1:0]      word_data,
    output logic [ADDR_W-1:0]      word_row,
    output logic [4:0]             word_col,
    output logic                   word_last
);

    localparam int                COLS      = 32;
    localparam int                ROW_W     = COLS * WORD_W;
    localparam logic [2:0]        WAIT_LAST = 3'(RD_LAT - 1);
    localparam logic [4:0]        LAST_COL  = 5'd31;
    localparam logic [4:0]        PEN_COL   = 5'd30;
    localparam logic [ADDR_W:0]   ONE_ROW   = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   row_q;
    logic [ADDR_W-1:0]   row_d;
    logic [ADDR_W:0]     rows_left_q;
    logic [2:0]          wait_cnt_q;
    logic [ROW_W-1:0]    shift_q;
    logic [4:0]          col_q;
    logic                busy_q;
    logic                done_q;
    logic                ram_ena_q;
    logic [ADDR_W-1:0]   ram_address_q;
    logic                word_valid_q;
    logic                word_last_q;

    // Next row in the run; wraps modulo the row count by natural overflow.
    assign row_d = row_q + 1'b1;

    // Sequencer: address phase, latency wait, then element-by-element drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            row_q         <= '0;
            rows_left_q   <= '0;
            wait_cnt_q    <= '0;
            shift_q       <= '0;
            col_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ram_ena_q     <= 1'b0;
            ram_address_q <= '0;
            word_valid_q  <= 1'b0;
            word_last_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (num_rows != '0) begin
                            row_q         <= base_row;
                            rows_left_q   <= num_rows;
                            ram_address_q <= base_row;
                            ram_ena_q     <= 1'b1;
                            busy_q        <= 1'b1;
                            state_q       <= S_ADDR;
                        end else begin
                            // Empty run: report completion without touching the RAM.
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_ADDR: begin
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        shift_q      <= ram_data_out;
                        ram_ena_q    <= 1'b0;
                        word_valid_q <= 1'b1;
                        col_q        <= '0;
                        word_last_q  <= 1'b0;
                        state_q      <= S_SHIFT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 3'd1;
                    end
                end
                S_SHIFT: begin
                    if (word_ready) begin
                        if (col_q == LAST_COL) begin
                            word_valid_q <= 1'b0;
                            word_last_q  <= 1'b0;
                            if (rows_left_q > ONE_ROW) begin
                                rows_left_q   <= rows_left_q - ONE_ROW;
                                row_q         <= row_d;
                                ram_address_q <= row_d;
                                ram_ena_q     <= 1'b1;
                                state_q       <= S_ADDR;
                            end else begin
                                rows_left_q <= '0;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
                                state_q     <= S_DONE;
                            end
                        end else begin
                            // Column 0 sits in the top bits, so shift left to expose the next one.
                            shift_q     <= {shift_q[ROW_W-WORD_W-1:0], {WORD_W{1'b0}}};
                            col_q       <= col_q + 5'd1;
                            word_last_q <= (col_q == PEN_COL) && (rows_left_q == ONE_ROW);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign ram_ena        = ram_ena_q;
    assign ram_read_write = 1'b0;
    assign ram_address    = ram_address_q;
    assign word_valid     = word_valid_q;
    assign word_data      = shift_q[ROW_W-1 -: WORD_W];
    assign word_row       = row_q;
    assign word_col       = col_q;
    assign word_last      = word_last_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_row_reader.sv
`default_nettype none

module tb_ram_row_reader;

    localparam int RD_LAT = 1;

    logic          clk;
    logic          reset;
    logic          start;
    logic [4:0]    base_row;
    logic [5:0]    num_rows;
    logic          busy;
    logic          done;
    logic          ram_ena;
    logic          ram_read_write;
    logic [4:0]    ram_address;
    logic [1023:0] ram_data_out;
    logic          word_valid;
    logic          word_ready;
    logic [31:0]   word_data;
    logic [4:0]    word_row;
    logic [4:0]    word_col;
    logic          word_last;

    ram_row_reader #(.RD_LAT(RD_LAT), .ADDR_W(5), .WORD_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_row       (base_row),
        .num_rows       (num_rows),
        .busy           (busy),
        .done           (done),
        .ram_ena        (ram_ena),
        .ram_read_write (ram_read_write),
        .ram_address    (ram_address),
        .ram_data_out   (ram_data_out),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .word_data      (word_data),
        .word_row       (word_row),
        .word_col       (word_col),
        .word_last      (word_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read pipeline of RD_LAT stages.
    logic [1023:0] mem  [32];
    logic [1023:0] pipe [RD_LAT];
    always @(posedge clk) begin
        if (ram_ena) pipe[0] <= mem[ram_address];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_data_out = pipe[RD_LAT-1];

    typedef struct {
        logic [31:0] data;
        logic [4:0]  row;
        logic [4:0]  col;
        logic        last;
        int          cyc;
    } xfer_t;

    xfer_t exp_q[$];
    xfer_t obs[$];
    int    obs_rd;
    int    checks;
    int    failures;

    // Monitor: records transfers and event counts at the falling edge.
    int          cyc, done_cnt, done_cyc, ena_cnt, valid_cnt, busy_cnt, rw_cnt, hold_err;
    logic        ena_prev, prev_stall;
    logic [42:0] prev_out;
    int          addr_log[$];
    initial begin
        cyc = 0; done_cnt = 0; done_cyc = 0; ena_cnt = 0; valid_cnt = 0;
        busy_cnt = 0; rw_cnt = 0; hold_err = 0; ena_prev = 1'b0; prev_stall = 1'b0;
        prev_out = '0;
    end
    always @(negedge clk) begin
        xfer_t t;
        cyc++;
        if (word_valid && word_ready) begin
            t.data = word_data; t.row = word_row; t.col = word_col;
            t.last = word_last; t.cyc = cyc;
            obs.push_back(t);
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (ram_ena) begin
            ena_cnt++;
            if (!ena_prev) addr_log.push_back(int'(ram_address));
        end
        ena_prev = ram_ena;
        if (word_valid) valid_cnt++;
        if (busy) busy_cnt++;
        if (ram_read_write) rw_cnt++;
        if (prev_stall && word_valid &&
            ({word_data, word_row, word_col, word_last} !== prev_out)) hold_err++;
        prev_stall = word_valid && !word_ready;
        prev_out   = {word_data, word_row, word_col, word_last};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] base, input int n);
        xfer_t e;
        logic [4:0] rr;
        for (int r = 0; r < n; r++) begin
            rr = base + 5'(r);
            for (int c = 0; c < 32; c++) begin
                e.data = mem[rr][1023-32*c -: 32];
                e.row  = rr;
                e.col  = 5'(c);
                e.last = (r == n-1) && (c == 31);
                e.cyc  = 0;
                exp_q.push_back(e);
            end
        end
    endtask

    // Drives a one-cycle start; returns just after the accepting edge with its cycle index.
    task automatic start_run(input logic [4:0] base, input logic [5:0] n, output int scyc);
        start = 1'b1; base_row = base; num_rows = n;
        @(posedge clk);
        scyc = cyc;
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int limit, input string name);
        int n = 0;
        while (done_cnt == base && n < limit) begin step(); n++; end
        checks++;
        if (done_cnt == base) begin
            failures++;
            $display("FAIL %s_timeout got done_cnt=%0d want>%0d", name, done_cnt, base);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; base_row = '0; num_rows = '0; word_ready = 1'b0;
        repeat (3) step();
        checks++;
        if ({busy, done, ram_ena, ram_read_write, ram_address, word_valid, word_data,
             word_row, word_col, word_last} !== 53'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b ena=%b addr=%0d valid=%b data=%h want all 0",
                     busy, done, ram_ena, ram_address, word_valid, word_data);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int sc, d0, e0, a0;
        xfer_t e, o;
        word_ready = 1'b1;
        d0 = done_cnt; e0 = ena_cnt; a0 = addr_log.size();
        push_exp(5'd3, 1);
        start_run(5'd3, 6'd1, sc);
        wait_done(d0, 200, "basic");
        step();
        checks++;
        if (ena_cnt - e0 != 1 + RD_LAT) begin
            failures++; $display("FAIL basic_ena_cycles got=%0d want=%0d", ena_cnt - e0, 1 + RD_LAT);
        end
        checks++;
        if (addr_log.size() != a0 + 1 || addr_log[a0] != 3) begin
            failures++; $display("FAIL basic_address got entries=%0d want one at row 3", addr_log.size() - a0);
        end
        checks++;
        if (obs.size() - obs_rd != 32) begin
            failures++; $display("FAIL basic_count got=%0d want=32", obs.size() - obs_rd);
        end
        checks++;
        if (obs.size() > obs_rd && obs[obs_rd].cyc != sc + 2 + RD_LAT) begin
            failures++; $display("FAIL basic_first_valid got cyc=%0d want=%0d", obs[obs_rd].cyc, sc + 2 + RD_LAT);
        end
        checks++;
        if (obs.size() > 0 && done_cyc != obs[obs.size()-1].cyc + 1) begin
            failures++; $display("FAIL basic_done_timing got=%0d want=%0d", done_cyc, obs[obs.size()-1].cyc + 1);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++; $display("FAIL basic_done_count got=%0d want=1", done_cnt - d0);
        end
        while (exp_q.size() > 0 && obs_rd < obs.size()) begin
            e = exp_q.pop_front(); o = obs[obs_rd]; obs_rd++;
            checks++;
            if (o.data !== e.data || o.row !== e.row || o.col !== e.col || o.last !== e.last) begin
                failures++;
                $display("FAIL basic_word got d=%h r=%0d c=%0d l=%b want d=%h r=%0d c=%0d l=%b",
                         o.data, o.row, o.col, o.last, e.data, e.row, e.col, e.last);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_stall();
        int sc, d0, v0, h0, n;
        bit tog;
        xfer_t e, o;
        d0 = done_cnt; v0 = valid_cnt; h0 = hold_err; tog = 0; n = 0;
        word_ready = 1'b0;
        push_exp(5'd12, 1);
        start_run(5'd12, 6'd1, sc);
        while (done_cnt == d0 && n < 300) begin
            step(); n++;
            if (tog) word_ready = ~word_ready;
            if (word_valid && !tog) begin tog = 1; word_ready = 1'b0; end
        end
        word_ready = 1'b1;
        checks++;
        if (done_cnt == d0) begin failures++; $display("FAIL stall_timeout got no done want done"); end
        checks++;
        if (valid_cnt - v0 != 64) begin
            failures++; $display("FAIL stall_shift_cycles got=%0d want=64", valid_cnt - v0);
        end
        checks++;
        if (hold_err != h0) begin
            failures++; $display("FAIL stall_hold got changes=%0d want=0", hold_err - h0);
        end
        checks++;
        if (obs.size() - obs_rd != 32) begin
            failures++; $display("FAIL stall_count got=%0d want=32", obs.size() - obs_rd);
        end
        while (exp_q.size() > 0 && obs_rd < obs.size()) begin
            e = exp_q.pop_front(); o = obs[obs_rd]; obs_rd++;
            checks++;
            if (o.data !== e.data || o.row !== e.row || o.col !== e.col || o.last !== e.last) begin
                failures++;
                $display("FAIL stall_word got d=%h c=%0d l=%b want d=%h c=%0d l=%b",
                         o.data, o.col, o.last, e.data, e.col, e.last);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_wrap();
        int sc, d0, a0;
        xfer_t e, o;
        int want_addr[4];
        want_addr = '{30, 31, 0, 1};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++)
                mem[(30 + r) % 32][1023-32*c -: 32] = 32'hA000_0000 + 32'((30 + r) % 32);
        word_ready = 1'b1;
        d0 = done_cnt; a0 = addr_log.size();
        push_exp(5'd30, 4);
        start_run(5'd30, 6'd4, sc);
        wait_done(d0, 800, "wrap");
        checks++;
        if (addr_log.size() - a0 != 4) begin
            failures++; $display("FAIL wrap_addr_count got=%0d want=4", addr_log.size() - a0);
        end
        for (int i = 0; i < 4 && a0 + i < addr_log.size(); i++) begin
            checks++;
            if (addr_log[a0+i] != want_addr[i]) begin
                failures++; $display("FAIL wrap_addr got=%0d want=%0d", addr_log[a0+i], want_addr[i]);
            end
        end
        checks++;
        if (obs.size() - obs_rd != 128) begin
            failures++; $display("FAIL wrap_count got=%0d want=128", obs.size() - obs_rd);
        end
        while (exp_q.size() > 0 && obs_rd < obs.size()) begin
            e = exp_q.pop_front(); o = obs[obs_rd]; obs_rd++;
            checks++;
            if (o.data !== e.data || o.row !== e.row || o.col !== e.col || o.last !== e.last) begin
                failures++;
                $display("FAIL wrap_word got d=%h r=%0d c=%0d l=%b want d=%h r=%0d c=%0d l=%b",
                         o.data, o.row, o.col, o.last, e.data, e.row, e.col, e.last);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_zero_rows();
        int sc, d0, e0, v0, b0;
        d0 = done_cnt; e0 = ena_cnt; v0 = valid_cnt; b0 = busy_cnt;
        start_run(5'd7, 6'd0, sc);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL zero_done got done=%b busy=%b want done=1 busy=0", done, busy);
        end
        step();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL zero_pulse got done=%b want 0", done); end
        repeat (5) step();
        checks++;
        if (done_cnt - d0 != 1 || ena_cnt != e0 || valid_cnt != v0 || busy_cnt != b0) begin
            failures++;
            $display("FAIL zero_quiet got done=%0d ena=%0d valid=%0d busy=%0d want 1 0 0 0",
                     done_cnt - d0, ena_cnt - e0, valid_cnt - v0, busy_cnt - b0);
        end
    endtask

    task automatic test_ignore_start();
        int sc, d0, v0, n;
        bit pulsed;
        xfer_t e, o;
        word_ready = 1'b1;
        d0 = done_cnt; v0 = valid_cnt; n = 0; pulsed = 0;
        push_exp(5'd10, 2);
        start_run(5'd10, 6'd2, sc);
        while (done_cnt == d0 && n < 400) begin
            step(); n++;
            start = 1'b0;
            if (!pulsed && word_valid && word_col == 5'd5) begin
                pulsed = 1; start = 1'b1; base_row = 5'd20; num_rows = 6'd3;
            end
        end
        start = 1'b0;
        repeat (40) step();
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++; $display("FAIL ignore_done_count got=%0d want=1", done_cnt - d0);
        end
        checks++;
        if (valid_cnt - v0 != 64 || busy !== 1'b0) begin
            failures++; $display("FAIL ignore_valid got=%0d busy=%b want 64 busy=0", valid_cnt - v0, busy);
        end
        checks++;
        if (obs.size() - obs_rd != 64) begin
            failures++; $display("FAIL ignore_count got=%0d want=64", obs.size() - obs_rd);
        end
        while (exp_q.size() > 0 && obs_rd < obs.size()) begin
            e = exp_q.pop_front(); o = obs[obs_rd]; obs_rd++;
            checks++;
            if (o.data !== e.data || o.row !== e.row || o.col !== e.col || o.last !== e.last) begin
                failures++;
                $display("FAIL ignore_word got d=%h r=%0d c=%0d want d=%h r=%0d c=%0d",
                         o.data, o.row, o.col, e.data, e.row, e.col);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_mid_reset();
        int sc, d0, n;
        xfer_t e, o;
        word_ready = 1'b1;
        d0 = done_cnt; n = 0;
        start_run(5'd3, 6'd1, sc);
        while (!(word_valid && word_col == 5'd10) && n < 100) begin step(); n++; end
        checks++;
        if (!(word_valid && word_col == 5'd10)) begin
            failures++; $display("FAIL midrst_reach got col=%0d valid=%b want col 10", word_col, word_valid);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, ram_ena, ram_address, word_valid, word_data, word_row, word_col,
             word_last} !== 52'd0) begin
            failures++;
            $display("FAIL midrst_async got busy=%b valid=%b data=%h col=%0d want all 0",
                     busy, word_valid, word_data, word_col);
        end
        repeat (3) step();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (done_cnt != d0 || busy !== 1'b0 || word_valid !== 1'b0) begin
            failures++; $display("FAIL midrst_nodone got done=%0d busy=%b want 0 0", done_cnt - d0, busy);
        end
        checks++;
        if (obs.size() - obs_rd != 10) begin
            failures++; $display("FAIL midrst_partial got=%0d want=10", obs.size() - obs_rd);
        end
        obs_rd = obs.size();
        d0 = done_cnt;
        push_exp(5'd7, 1);
        start_run(5'd7, 6'd1, sc);
        wait_done(d0, 200, "midrst_fresh");
        checks++;
        if (obs.size() - obs_rd != 32) begin
            failures++; $display("FAIL midrst_fresh_count got=%0d want=32", obs.size() - obs_rd);
        end
        while (exp_q.size() > 0 && obs_rd < obs.size()) begin
            e = exp_q.pop_front(); o = obs[obs_rd]; obs_rd++;
            checks++;
            if (o.data !== e.data || o.row !== e.row || o.col !== e.col || o.last !== e.last) begin
                failures++;
                $display("FAIL midrst_word got d=%h c=%0d l=%b want d=%h c=%0d l=%b",
                         o.data, o.col, o.last, e.data, e.col, e.last);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        checks = 0; failures = 0; obs_rd = 0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                mem[r][1023-32*c -: 32] = {8'(r), 8'(c), 16'h5A5A};
        for (int c = 0; c < 32; c++) mem[3][1023-32*c -: 32] = 32'(c + 1);

        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero_rows();
        test_ignore_start();
        test_mid_reset();

        checks++;
        if (rw_cnt != 0) begin
            failures++; $display("FAIL read_write got high cycles=%0d want 0", rw_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_row_reader.md
Name: ram_row_reader

Overview:
- Read-side master for the 32-row x 1024-bit matrix RAM in the Jacobi datapath.
- On `start`, fetches a run of consecutive rows from the RAM read port.
- Each fetched row is serialised into 32 x 32-bit matrix elements on a valid/ready stream.
- Feeds the rotation/pivot-search units, which consume one element at a time.

Parameters:
- RD_LAT, 1, RAM read latency in clock cycles from address/ena presented to `ram_data_out` valid (range 1..4).
- ADDR_W, 5, row address width (32 rows).
- WORD_W, 32, element width; row width is 32*WORD_W = 1024.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_row  in  5  first row to read; sampled with start.
- num_rows  in  6  number of rows to read, 0..32; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the run completes.
- ram_ena  out  1  RAM enable.
- ram_read_write  out  1  RAM direction; constant 0 (read); 1 is write and is never driven.
- ram_address  out  5  RAM row address.
- ram_data_out  in  1024  RAM read data.
- word_valid  out  1  element available.
- word_ready  in  1  consumer accepts element.
- word_data  out  32  matrix element.
- word_row  out  5  row index of the element.
- word_col  out  5  column index, 0..31.
- word_last  out  1  high on the final element of the run (last row, col 31).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0.
  - busy, done, ram_ena, ram_address, word_valid, word_data, word_row, word_col, word_last = 0.
  - Internal row counter, shift register and WAIT counter are cleared.
- Reset asserted mid-run aborts the run immediately; no done pulse is produced.
- FSM states: IDLE, ADDR, WAIT, SHIFT, DONE.
- IDLE:
  - start=1 with num_rows!=0: latch base_row and num_rows, go to ADDR.
  - start=1 with num_rows=0: go to DONE. No RAM access, no words emitted.
  - start while not in IDLE is ignored.
- ADDR (1 cycle): ram_ena=1, ram_read_write=0, ram_address=current row. Go to WAIT.
- WAIT (RD_LAT cycles): ram_ena and ram_address held. On the edge ending the last WAIT cycle, capture `ram_data_out` into a 1024-bit holding register. Go to SHIFT.
- ram_ena=0 in SHIFT, DONE and IDLE. ram_address holds its last value.
- SHIFT:
  - word_valid=1.
  - word_data = column `word_col` of the captured row. Column 0 = bits [1023:992]; column c = bits [1023-32c -: 32].
  - A transfer occurs on an edge where word_valid & word_ready.
  - word_data, word_row, word_col and word_last are stable while word_valid=1 and word_ready=0.
  - After the col-31 transfer: rows remaining, so advance row and go to ADDR; otherwise go to DONE.
  - No gap cycles between columns of the same row.
- Row increment wraps modulo 32 (base_row=30, num_rows=4 reads rows 30, 31, 0, 1).
- DONE (1 cycle): done=1, busy=0. Then IDLE. start is not accepted in DONE.
- busy=1 in ADDR, WAIT and SHIFT.
- Timing with start accepted at edge k:
  - ADDR occupies cycle k..k+1.
  - First word_valid rises at edge k+1+RD_LAT.
  - Zero backpressure costs 1+RD_LAT+32 cycles per row.
- word_last=1 only with the final transfer of the run.

Test Plan:
- Load row 3 with element c = c+1, RD_LAT=1. start with base_row=3, num_rows=1, word_ready=1:
  - ram_ena high exactly 2 cycles at address 3, ram_read_write=0 throughout.
  - word_valid from start edge+2.
  - 32 words 1..32, word_col 0..31, word_row=3.
  - word_last on col 31; done pulse 1 cycle later.
- Toggle word_ready 1/0 every cycle during a row:
  - Each element is delivered exactly once, in order.
  - Outputs are held during stall cycles.
  - Run takes 64 SHIFT cycles for the row.
- base_row=30, num_rows=4, row r preloaded with 0xA000_0000+r in every column:
  - ram_address sequence 30, 31, 0, 1.
  - 128 words; word_last only on row 1, col 31.
- start with num_rows=0: done pulses on the next edge, busy stays 0, ram_ena stays 0, no word_valid.
- Pulse start again during SHIFT of a 2-row run: ignored; exactly 64 words and one done pulse.
- Drive reset=0 mid-SHIFT at col 10: all outputs 0 asynchronously, state IDLE, no done. A fresh start then completes normally.
